// File: rtl/burst_master.sv
`default_nettype none
// ============================================================================
// Module      : burst_master
// Description : Initiator for the 4-bit, 8-deep burst memory slave. Takes one
//               command at a time from the local controller. A write buffers
//               BURST_LEN user beats, then runs address, data and response
//               phases. A read runs an address phase and forwards each
//               returned beat. A per-wait timeout aborts a hung slave
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_master #(
  parameter int BURST_LEN = 8,   // beats per burst, 1..8
  parameter int TIMEOUT   = 64   // max stalled cycles per slave wait, 0 = off
) (
  input  logic       clk,
  input  logic       rst,
  // local controller command channel
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  // local controller write-data channel
  input  logic       wd_valid,
  output logic       wd_ready,
  input  logic [3:0] wd_data,
  // local controller read-data and status
  output logic       rd_valid,
  output logic [3:0] rd_data,
  output logic       done,
  output logic       err,
  output logic       busy,
  // slave write address channel
  output logic       aw_valid,
  input  logic       aw_ready,
  output logic [2:0] aw_addr,
  // slave write data channel
  output logic       w_valid,
  input  logic       w_ready,
  output logic [3:0] w_data,
  // slave write response channel
  input  logic       b_valid,
  output logic       b_ready,
  // slave read address channel
  output logic       ar_valid,
  input  logic       ar_ready,
  output logic [2:0] ar_addr,
  // slave read data channel
  input  logic       r_valid,
  output logic       r_ready,
  input  logic [3:0] r_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_AW   = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_AR   = 3'd5,
    S_R    = 3'd6
  } state_t;

  // Index of the final beat of a burst.
  localparam logic [3:0]  c_LAST_BEAT = 4'(BURST_LEN - 1);
  // Timeout fires when the stalled-cycle count would reach TIMEOUT.
  localparam bit          c_TO_EN     = (TIMEOUT > 0);
  localparam logic [15:0] c_TO_LAST   = 16'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_cnt;        // beat counter for FILL, W and R
  logic [15:0] r_wait;       // stalled cycles on the active slave channel
  logic [2:0]  r_addr;       // burst address latched at command accept
  logic        r_write;      // burst direction latched at command accept
  logic [2:0]  r_aw_addr;
  logic [2:0]  r_ar_addr;
  logic [3:0]  r_rd_data;
  logic        r_rd_valid;
  logic        r_done;
  logic        r_err;

  // Write data buffer; contents survive reset on purpose.
  logic [3:0]  r_buf [0:7];

  logic        w_last;       // current beat is the last of the burst
  logic        w_timed;      // state waits on a slave handshake
  logic        w_hs;         // handshake on the active slave channel
  logic        w_timeout;    // abort this cycle

  assign w_last = (r_cnt == c_LAST_BEAT);

  // Channel controls come straight from the registered state so that no
  // slave input reaches a valid/ready output combinationally.
  assign cmd_ready = (r_state == S_IDLE);
  assign wd_ready  = (r_state == S_FILL);
  assign aw_valid  = (r_state == S_AW);
  assign w_valid   = (r_state == S_W);
  assign b_ready   = (r_state == S_B);
  assign ar_valid  = (r_state == S_AR);
  assign r_ready   = (r_state == S_R);
  assign busy      = (r_state != S_IDLE);

  assign aw_addr   = r_aw_addr;
  assign ar_addr   = r_ar_addr;
  assign w_data    = r_buf[r_cnt[2:0]];
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign err       = r_err;

  // State register; asynchronous reset drops every valid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, active-channel handshake and timeout detection.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_timed     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = cmd_write ? S_FILL : S_AR;
        end
      end
      S_FILL: begin
        if (wd_valid && w_last) begin
          w_state_nxt = S_AW;
        end
      end
      S_AW: begin
        w_timed = 1'b1;
        w_hs    = aw_ready;
        if (w_hs) begin
          w_state_nxt = S_W;
        end
      end
      S_W: begin
        w_timed = 1'b1;
        w_hs    = w_ready;
        if (w_hs && w_last) begin
          w_state_nxt = S_B;
        end
      end
      S_B: begin
        // The latched direction qualifies the response channel.
        w_timed = 1'b1;
        w_hs    = b_valid && r_write;
        if (w_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_AR: begin
        w_timed = 1'b1;
        w_hs    = ar_ready;
        if (w_hs) begin
          w_state_nxt = S_R;
        end
      end
      S_R: begin
        w_timed = 1'b1;
        w_hs    = r_valid && !r_write;
        if (w_hs && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // A handshake in the same cycle as the limit always wins.
    w_timeout = c_TO_EN && w_timed && !w_hs && (r_wait == c_TO_LAST);
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Counters, latched command fields, address outputs and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_wait     <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_aw_addr  <= '0;
      r_ar_addr  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= w_timeout;

      // Wait counter restarts on every handshake and on every state change.
      if (!w_timed || w_hs || (w_state_nxt != r_state)) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_write <= cmd_write;
            r_cnt   <= '0;
            if (!cmd_write) begin
              r_ar_addr <= cmd_addr;
            end
          end
        end
        S_FILL: begin
          if (wd_valid) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
              r_aw_addr <= r_addr;
            end
          end
        end
        S_AW: begin
          if (w_hs) begin
            r_cnt <= '0;
          end
        end
        S_W: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_B: begin
          if (w_hs) begin
            r_done <= 1'b1;
          end
        end
        S_AR: begin
          if (w_hs) begin
            r_cnt <= '0;
          end
        end
        S_R: begin
          if (w_hs) begin
            r_rd_data  <= r_data;
            r_rd_valid <= 1'b1;
            r_cnt      <= r_cnt + 4'd1;
            // Done lines up with the final forwarded beat.
            if (w_last) begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Capture user write beats into the buffer while filling.
  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && wd_valid) begin
      r_buf[r_cnt[2:0]] <= wd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_master
// Description : Scoreboard bench for burst_master with a behavioural slave
//               and a burst-level reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_master;

  localparam int BL = 8;
  localparam int TO = 16;
  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic       wd_valid, wd_ready;
  logic [3:0] wd_data;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       done, err, busy;
  logic       aw_valid, aw_ready;
  logic [2:0] aw_addr;
  logic       w_valid, w_ready;
  logic [3:0] w_data;
  logic       b_valid, b_ready;
  logic       ar_valid, ar_ready;
  logic [2:0] ar_addr;
  logic       r_valid, r_ready;
  logic [3:0] r_data;

  burst_master #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err), .busy(busy),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ev_cnt = 0;

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic [2:0] exp_aw[$];
  logic [2:0] exp_ar[$];
  logic [3:0] exp_w[$];
  logic [3:0] exp_rd[$];
  logic [1:0] exp_ev[$];

  // Reference model: burst contents per address after each completed write.
  logic [3:0] ref_mem [64];
  bit         written [8];
  logic [3:0] tdata [BL];

  // Slave behaviour knobs.
  bit fixed3    = 1'b0;
  bit ar_never  = 1'b0;
  int max_stall = 0;
  int low [5];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_msg(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // Ready decision with a bounded run of stalled cycles per channel.
  function automatic bit rdy(input int ch);
    bit b;
    if (fixed3 && ch == 1) b = (low[ch] >= 3);
    else                   b = (low[ch] >= max_stall) || ($urandom_range(0, 1) == 1);
    low[ch] = b ? 0 : low[ch] + 1;
    return b;
  endfunction

  // Behavioural slave plus output monitor, all sampled on the falling edge.
  initial begin : slave_mon
    logic p_aw_v, p_aw_r, p_w_v, p_w_r, p_b_v, p_b_r, p_ar_v, p_ar_r, p_r_v, p_r_r;
    logic [2:0] p_aw_a, p_ar_a, wa, ra;
    logic [3:0] p_w_d, e;
    logic [3:0] smem [64];
    logic [3:0] wbuf [BL];
    int wk, rk;
    bit b_pend, r_act;
    {p_aw_v, p_aw_r, p_w_v, p_w_r, p_b_v, p_b_r, p_ar_v, p_ar_r, p_r_v, p_r_r} = '0;
    p_aw_a = '0; p_ar_a = '0; p_w_d = '0; wa = '0; ra = '0;
    wk = 0; rk = 0; b_pend = 1'b0; r_act = 1'b0;
    for (int i = 0; i < 64; i++) smem[i] = '0;
    for (int i = 0; i < 5; i++) low[i] = 0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {p_aw_v, p_aw_r, p_w_v, p_w_r, p_b_v, p_b_r, p_ar_v, p_ar_r, p_r_v, p_r_r} = '0;
        wk = 0; rk = 0; b_pend = 1'b0; r_act = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; ar_ready = 1'b0; r_valid = 1'b0;
        continue;
      end
      // Handshakes that happened on the rising edge just past.
      if (p_aw_v && p_aw_r) begin
        if (exp_aw.size() == 0) fail_msg("aw_unexpected");
        else chk("aw_addr", p_aw_a, exp_aw.pop_front());
        wa = p_aw_a; wk = 0;
      end
      if (p_w_v && p_w_r) begin
        if (exp_w.size() == 0) fail_msg("w_unexpected");
        else chk("w_data", p_w_d, exp_w.pop_front());
        if (wk < BL) wbuf[wk] = p_w_d;
        wk++;
        if (wk == BL) b_pend = 1'b1;
      end
      if (p_b_v && p_b_r) begin
        b_valid = 1'b0; b_pend = 1'b0;
        for (int k = 0; k < BL; k++) smem[int'(wa) * BL + k] = wbuf[k];
        chk("done_after_b", done, 1);
        chk("busy_after_b", busy, 0);
      end
      if (p_ar_v && p_ar_r) begin
        if (exp_ar.size() == 0) fail_msg("ar_unexpected");
        else chk("ar_addr", p_ar_a, exp_ar.pop_front());
        ra = p_ar_a; rk = 0; r_act = 1'b1;
      end
      if (p_r_v && p_r_r) begin
        r_valid = 1'b0;
        rk++;
        if (rk == BL) r_act = 1'b0;
      end
      // Payload must stay put while the slave stalls.
      if (p_w_v && !p_w_r) begin
        chk("w_hold_valid", w_valid, 1);
        chk("w_hold_data", w_data, p_w_d);
      end
      if (p_aw_v && !p_aw_r) begin
        chk("aw_hold_valid", aw_valid, 1);
        chk("aw_hold_addr", aw_addr, p_aw_a);
      end
      // Controller-side outputs.
      if (rd_valid) begin
        if (exp_rd.size() == 0) fail_msg("rd_unexpected");
        else begin
          e = exp_rd.pop_front();
          chk("rd_data", rd_data, e);
          chk("rd_done_align", done, (exp_rd.size() == 0));
        end
      end
      if (done || err) begin
        if (exp_ev.size() == 0) fail_msg("event_unexpected");
        else chk("event_kind", {done, err}, exp_ev.pop_front());
        ev_cnt++;
      end
      // Drive the slave side for the next rising edge.
      aw_ready = aw_valid ? rdy(0) : 1'b0;
      w_ready  = w_valid ? rdy(1) : 1'b0;
      if (b_pend && !b_valid) b_valid = rdy(2);
      ar_ready = (ar_valid && !ar_never) ? rdy(3) : 1'b0;
      if (r_act && !r_valid && rdy(4)) begin
        r_valid = 1'b1;
        r_data  = smem[int'(ra) * BL + rk];
      end
      p_aw_v = aw_valid; p_aw_r = aw_ready; p_aw_a = aw_addr;
      p_w_v  = w_valid;  p_w_r  = w_ready;  p_w_d  = w_data;
      p_b_v  = b_valid;  p_b_r  = b_ready;
      p_ar_v = ar_valid; p_ar_r = ar_ready; p_ar_a = ar_addr;
      p_r_v  = r_valid;  p_r_r  = r_ready;
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic issue_cmd(input logic wr, input logic [2:0] a);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) fail_msg("cmd_accept_timeout");
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed_wd();
    int n;
    for (int k = 0; k < BL; k++) begin
      if ($urandom_range(0, 3) == 0) begin wd_valid = 1'b0; @(negedge clk); end
      wd_valid = 1'b1; wd_data = tdata[k];
      n = 0;
      while (!wd_ready && n < 200) begin @(negedge clk); n++; end
      if (!wd_ready) fail_msg("wd_accept_timeout");
      @(negedge clk);
    end
    wd_valid = 1'b0;
  endtask

  task automatic recover();
    rst = 1'b1;
    exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_rd.delete(); exp_ev.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ev(input int e0);
    int n;
    n = 0;
    while (ev_cnt == e0 && n < 1000) begin @(negedge clk); n++; end
    if (ev_cnt == e0) begin
      fail_msg("burst_completion_timeout");
      recover();
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < BL; k++) tdata[k] = 4'($urandom_range(0, 15));
  endtask

  task automatic do_write(input logic [2:0] a);
    int e0;
    exp_aw.push_back(a);
    for (int k = 0; k < BL; k++) exp_w.push_back(tdata[k]);
    exp_ev.push_back(EV_DONE);
    e0 = ev_cnt;
    issue_cmd(1'b1, a);
    feed_wd();
    wait_ev(e0);
    for (int k = 0; k < BL; k++) ref_mem[int'(a) * BL + k] = tdata[k];
    written[a] = 1'b1;
  endtask

  task automatic start_read(input logic [2:0] a);
    exp_ar.push_back(a);
    for (int k = 0; k < BL; k++) exp_rd.push_back(ref_mem[int'(a) * BL + k]);
    exp_ev.push_back(EV_DONE);
    issue_cmd(1'b0, a);
  endtask

  task automatic do_read(input logic [2:0] a);
    int e0;
    e0 = ev_cnt;
    start_read(a);
    wait_ev(e0);
  endtask

  initial begin : stim
    int k, e0;
    logic [2:0] a;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    wd_valid = 1'b0; wd_data = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8; i++) written[i] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {wd_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready}, 0);
    chk("rst_status", {rd_valid, done, err}, 0);
    chk("rst_addrs", {aw_addr, ar_addr}, 0);
    chk("rst_rd_data", rd_data, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Write 1..8 to address 0 with an always-ready slave, then read it back.
    max_stall = 0;
    for (int i = 0; i < BL; i++) tdata[i] = 4'(i + 1);
    do_write(3'd0);
    do_read(3'd0);

    // Slave stalls w_ready three cycles before each beat.
    fixed3 = 1'b1; max_stall = 3;
    rand_data();
    do_write(3'd3);
    fixed3 = 1'b0;
    do_read(3'd3);

    // Read address never accepted: timeout abort.
    ar_never = 1'b1;
    exp_ev.push_back(EV_ERR);
    issue_cmd(1'b0, 3'd5);
    chk("ar_valid_raised", ar_valid, 1);
    k = 0;
    while (!err && k < 100) begin @(negedge clk); k++; end
    chk("timeout_cycles", k, TO);
    chk("timeout_ar_valid", ar_valid, 0);
    chk("timeout_cmd_ready", cmd_ready, 1);
    chk("timeout_no_done", done, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    ar_never = 1'b0;

    // Reset during the write data phase.
    max_stall = 0;
    rand_data();
    exp_aw.push_back(3'd2);
    for (int i = 0; i < BL; i++) exp_w.push_back(tdata[i]);
    exp_ev.push_back(EV_DONE);
    issue_cmd(1'b1, 3'd2);
    feed_wd();
    k = 0;
    while (exp_w.size() > BL - 4 && k < 200) begin @(negedge clk); k++; end
    #1 rst = 1'b1;
    #1;
    chk("midrst_valids", {aw_valid, w_valid, b_ready, ar_valid, r_ready, wd_ready}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_status", {done, err}, 0);
    exp_aw.delete(); exp_w.delete(); exp_ev.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_quiet", {done, err, busy}, 0);
    end
    rand_data();
    do_write(3'd2);
    do_read(3'd2);

    // Command pulse during an active read is ignored.
    max_stall = 1;
    e0 = ev_cnt;
    start_read(3'd0);
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd6;
    chk("cmd_ready_while_busy", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ev(e0);
    repeat (3) @(negedge clk);
    chk("no_second_burst", {busy, wd_ready, aw_valid, ar_valid}, 0);

    // Randomized mix of bursts with random slave stalls.
    for (int i = 0; i < 16; i++) begin
      max_stall = $urandom_range(0, 3);
      a = 3'($urandom_range(0, 7));
      if (written[a] && ($urandom_range(0, 1) == 1)) do_read(a);
      else begin rand_data(); do_write(a); end
    end

    repeat (4) @(negedge clk);
    if (exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size() + exp_ev.size() != 0)
      fail_msg("scoreboard_leftover");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
